// File: rtl/accel_host_sequencer_if.sv
// Bundles the streaming and accelerator-side signals of accel_host_sequencer.
//   master : sequencer side (drives s_ready, m_*, acc_* controls; reads s_*, m_ready, acc_rdata/acc_done)
//   slave  : environment side (host stream source, result sink, accelerator)
interface accel_host_sequencer_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 10
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [1:0]        acc_mem_sel;
  logic [DATA_W-1:0] acc_wdata;
  logic [ADDR_W-1:0] acc_addr;
  logic              acc_mem_wr;
  logic              acc_mem_rd;
  logic              acc_go;
  logic [DATA_W-1:0] acc_rdata;
  logic              acc_done;

  modport master (
    input  s_valid, s_data, m_ready, acc_rdata, acc_done,
    output s_ready, m_valid, m_data, acc_mem_sel, acc_wdata, acc_addr,
           acc_mem_wr, acc_mem_rd, acc_go
  );

  modport slave (
    output s_valid, s_data, m_ready, acc_rdata, acc_done,
    input  s_ready, m_valid, m_data, acc_mem_sel, acc_wdata, acc_addr,
           acc_mem_wr, acc_mem_rd, acc_go
  );
endinterface

// File: rtl/accel_host_sequencer.sv
// Host-side sequencer for the CNN-LSTM accelerator: streams conv weights,
// feature map and (optionally) LSTM coefficients into the accelerator,
// pulses go, waits for done with a timeout, then reads the h_t memory back
// out as a valid/ready stream.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   start/load_coef start request (IDLE only) and coefficient-phase select
//   bus (master)    s_* input stream, m_* result stream, acc_* accelerator port
//   busy            high in every state except IDLE
//   seq_done        one-cycle pulse after the last h_t word is accepted
//   err             sticky timeout flag, cleared by the next accepted start
module accel_host_sequencer #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned CW_LEN   = 72,
  parameter int unsigned FM_LEN   = 784,
  parameter int unsigned COEF_LEN = 512,
  parameter int unsigned HT_LEN   = 32,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned TIMEOUT  = 1048575
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  load_coef,
  accel_host_sequencer_if.master bus,
  output logic                  busy,
  output logic                  seq_done,
  output logic                  err
);

  localparam int unsigned MAX_A   = (CW_LEN > FM_LEN) ? CW_LEN : FM_LEN;
  localparam int unsigned MAX_B   = (COEF_LEN > HT_LEN) ? COEF_LEN : HT_LEN;
  localparam int unsigned MAX_LEN = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned IDX_W   = $clog2(MAX_LEN + 1);
  localparam int unsigned TMR_W   = $clog2(TIMEOUT + 1);
  localparam int unsigned LAT_W   = 2;

  localparam logic [1:0] SEL_FM   = 2'b00;
  localparam logic [1:0] SEL_HT   = 2'b01;
  localparam logic [1:0] SEL_COEF = 2'b10;
  localparam logic [1:0] SEL_CW   = 2'b11;

  typedef enum logic [3:0] {
    IDLE, LD_CW, LD_FM, LD_COEF, GO, WAIT, RD_ISSUE, RD_WAIT, RD_OUT, FIN
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              coef_q, coef_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [1:0]        mem_sel_q, mem_sel_d;
  logic              go_q, go_d;
  logic              rd_q, rd_d;
  logic              m_valid_q, m_valid_d;
  logic              busy_q, busy_d;
  logic              seq_done_q, seq_done_d;

  logic              s_ready;
  logic              mem_wr;
  logic [DATA_W-1:0] wdata;
  logic [IDX_W-1:0]  last_idx;
  state_e            next_phase;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    timer_d    = timer_q;
    lat_d      = lat_q;
    coef_d     = coef_q;
    err_d      = err_q;
    m_data_d   = m_data_q;
    s_ready    = 1'b0;
    mem_wr     = 1'b0;
    wdata      = '0;
    last_idx   = '0;
    next_phase = IDLE;

    // Length and successor of the current load phase.
    unique case (state_q)
      LD_CW: begin
        last_idx   = IDX_W'(CW_LEN - 1);
        next_phase = LD_FM;
      end
      LD_FM: begin
        last_idx   = IDX_W'(FM_LEN - 1);
        next_phase = coef_q ? LD_COEF : GO;
      end
      LD_COEF: begin
        last_idx   = IDX_W'(COEF_LEN - 1);
        next_phase = GO;
      end
      default: ;
    endcase

    unique case (state_q)
      IDLE: begin
        if (start) begin
          coef_d  = load_coef;
          err_d   = 1'b0;
          idx_d   = '0;
          state_d = LD_CW;
        end
      end
      LD_CW, LD_FM, LD_COEF: begin
        // Write is combinational with the accepted word so a word costs one cycle.
        s_ready = 1'b1;
        if (bus.s_valid) begin
          mem_wr = 1'b1;
          wdata  = bus.s_data;
          if (idx_q == last_idx) begin
            idx_d   = '0;
            state_d = next_phase;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      GO: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.acc_done) begin
          timer_d = '0;
          idx_d   = '0;
          state_d = RD_ISSUE;
        end else if (timer_q == TMR_W'(TIMEOUT)) begin
          timer_d = '0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      RD_ISSUE: begin
        lat_d   = '0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        // lat_q==k in the (k+1)-th cycle after the issue cycle.
        if (lat_q == LAT_W'(RD_LAT - 1)) begin
          m_data_d = bus.acc_rdata;
          state_d  = RD_OUT;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      RD_OUT: begin
        if (bus.m_ready) begin
          if (idx_q == IDX_W'(HT_LEN - 1)) begin
            idx_d   = '0;
            state_d = FIN;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = RD_ISSUE;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Registered outputs are decoded from the next state so they line up
    // with state_q in the cycle the state is occupied.
    unique case (state_d)
      LD_CW:   mem_sel_d = SEL_CW;
      LD_FM:   mem_sel_d = SEL_FM;
      LD_COEF: mem_sel_d = SEL_COEF;
      default: mem_sel_d = SEL_HT;
    endcase
    go_d       = (state_d == GO);
    rd_d       = (state_d == RD_ISSUE);
    m_valid_d  = (state_d == RD_OUT);
    busy_d     = (state_d != IDLE);
    seq_done_d = (state_d == FIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      timer_q    <= '0;
      lat_q      <= '0;
      coef_q     <= 1'b0;
      err_q      <= 1'b0;
      m_data_q   <= '0;
      mem_sel_q  <= SEL_HT;
      go_q       <= 1'b0;
      rd_q       <= 1'b0;
      m_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
      seq_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      lat_q      <= lat_d;
      coef_q     <= coef_d;
      err_q      <= err_d;
      m_data_q   <= m_data_d;
      mem_sel_q  <= mem_sel_d;
      go_q       <= go_d;
      rd_q       <= rd_d;
      m_valid_q  <= m_valid_d;
      busy_q     <= busy_d;
      seq_done_q <= seq_done_d;
    end
  end

  assign bus.s_ready     = s_ready;
  assign bus.acc_mem_wr  = mem_wr;
  assign bus.acc_wdata   = wdata;
  // idx is held through RD_ISSUE/RD_WAIT, so it also serves as the read address.
  assign bus.acc_addr    = ADDR_W'(idx_q);
  assign bus.acc_mem_sel = mem_sel_q;
  assign bus.acc_go      = go_q;
  assign bus.acc_mem_rd  = rd_q;
  assign bus.m_valid     = m_valid_q;
  assign bus.m_data      = m_data_q;
  assign busy            = busy_q;
  assign seq_done        = seq_done_q;
  assign err             = err_q;

endmodule

// File: tb/tb_accel_host_sequencer.sv
`timescale 1ns/1ps
module tb_accel_host_sequencer;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned CW_LEN   = 4;
  localparam int unsigned FM_LEN   = 6;
  localparam int unsigned COEF_LEN = 3;
  localparam int unsigned HT_LEN   = 32;
  localparam int unsigned RD_LAT   = 3;
  localparam int unsigned TIMEOUT  = 100;
  localparam int          DONE_DLY = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic load_coef = 1'b0;
  logic busy, seq_done, err;

  accel_host_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  accel_host_sequencer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CW_LEN(CW_LEN), .FM_LEN(FM_LEN),
    .COEF_LEN(COEF_LEN), .HT_LEN(HT_LEN), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .load_coef(load_coef),
    .bus(bus), .busy(busy), .seq_done(seq_done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]        sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t               wq[$];
  logic [DATA_W-1:0] mq[$];

  int n_checks = 0, n_fail = 0;
  int cyc = 0;
  int wr_cnt = 0, go_cnt = 0, done_cnt = 0, rd_exp = 0;
  int go_cyc = 0, last_wr_cyc = 0;
  logic done_en = 1'b1;
  int mr_mode = 0;
  logic [15:0] seed = 16'h0000;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] in_word(input int k, input logic [15:0] s);
    return DATA_W'(32'h1000 + k * 32'h0111 + 32'(s));
  endfunction

  function automatic logic [DATA_W-1:0] ht_word(input int a, input logic [15:0] s);
    return DATA_W'(32'hC300 ^ (a * 32'h0123) ^ 32'(s));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Accelerator model: done pulse DONE_DLY cycles after go.
  initial begin : done_model
    int cnt;
    logic go_seen;
    cnt = 0;
    bus.acc_done = 1'b0;
    forever begin
      @(negedge clk);
      go_seen = bus.acc_go && done_en && !reset;
      @(posedge clk); #1;
      bus.acc_done = 1'b0;
      if (reset) cnt = 0;
      else if (go_seen) cnt = DONE_DLY;
      else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) bus.acc_done = 1'b1;
      end
    end
  end

  // Accelerator model: h_t read data valid exactly RD_LAT cycles after mem_rd.
  initial begin : rd_model
    logic              pv[RD_LAT];
    logic [ADDR_W-1:0] pa[RD_LAT];
    logic              rv;
    logic [ADDR_W-1:0] ra;
    for (int i = 0; i < int'(RD_LAT); i++) begin pv[i] = 1'b0; pa[i] = '0; end
    bus.acc_rdata = DATA_W'(16'hBAD0);
    forever begin
      @(negedge clk);
      rv = bus.acc_mem_rd;
      ra = bus.acc_addr;
      @(posedge clk); #1;
      for (int i = int'(RD_LAT) - 1; i > 0; i--) begin pv[i] = pv[i-1]; pa[i] = pa[i-1]; end
      pv[0] = rv;
      pa[0] = ra;
      bus.acc_rdata = pv[RD_LAT-1] ? ht_word(int'(pa[RD_LAT-1]), seed) : DATA_W'(16'hBAD0);
    end
  end

  // Result consumer: 0 = always ready, 1 = 5-cycle stalls, other = never ready.
  initial begin : mready_drv
    int sc;
    sc = 0;
    bus.m_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (mr_mode)
        0: bus.m_ready = 1'b1;
        1: begin
          bus.m_ready = (sc == 5);
          sc = (sc == 5) ? 0 : sc + 1;
        end
        default: bus.m_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard queues whenever the DUT presents a transfer.
  initial begin : monitor
    wr_t               e;
    logic [DATA_W-1:0] me;
    logic              stall_prev;
    logic [DATA_W-1:0] stall_data;
    stall_prev = 1'b0;
    stall_data = '0;
    forever begin
      @(negedge clk);
      if (bus.acc_mem_wr) begin
        wr_cnt++;
        last_wr_cyc = cyc;
        if (wq.size() == 0) chk("wr_unexpected", 32'(bus.acc_mem_wr), 32'd0);
        else begin
          e = wq.pop_front();
          chk("wr_sel", 32'(bus.acc_mem_sel), 32'(e.sel));
          chk("wr_addr", 32'(bus.acc_addr), 32'(e.addr));
          chk("wr_data", 32'(bus.acc_wdata), 32'(e.data));
        end
      end
      if (bus.acc_go) begin
        go_cnt++;
        go_cyc = cyc;
      end
      if (bus.acc_mem_rd) begin
        chk("rd_addr", 32'(bus.acc_addr), 32'(rd_exp));
        rd_exp++;
      end
      if (bus.m_valid && bus.m_ready) begin
        if (mq.size() == 0) chk("m_unexpected", 32'(bus.m_valid), 32'd0);
        else begin
          me = mq.pop_front();
          chk("m_data", 32'(bus.m_data), 32'(me));
        end
      end else if (bus.m_valid && stall_prev) begin
        chk("m_stable", 32'(bus.m_data), 32'(stall_data));
      end
      stall_prev = bus.m_valid && !bus.m_ready;
      stall_data = bus.m_data;
      if (seq_done) done_cnt++;
    end
  end

  // All stimulus tasks start and end at posedge+1.
  task automatic start_seq(input logic lc, input logic push_m);
    int n;
    n = int'(CW_LEN + FM_LEN) + (lc ? int'(COEF_LEN) : 0);
    wq.delete();
    mq.delete();
    for (int k = 0; k < n; k++) begin
      wr_t e;
      if (k < int'(CW_LEN)) begin
        e.sel = 2'b11; e.addr = ADDR_W'(k);
      end else if (k < int'(CW_LEN + FM_LEN)) begin
        e.sel = 2'b00; e.addr = ADDR_W'(k - int'(CW_LEN));
      end else begin
        e.sel = 2'b10; e.addr = ADDR_W'(k - int'(CW_LEN + FM_LEN));
      end
      e.data = in_word(k, seed);
      wq.push_back(e);
    end
    if (push_m) for (int a = 0; a < int'(HT_LEN); a++) mq.push_back(ht_word(a, seed));
    wr_cnt = 0; go_cnt = 0; done_cnt = 0; rd_exp = 0;
    start = 1'b1;
    load_coef = lc;
    @(posedge clk); #1;
    start = 1'b0;
    load_coef = 1'b0;
  endtask

  task automatic feed(input int n, input logic bursty);
    int k, guard;
    logic acc;
    k = 0;
    guard = 0;
    while (k < n && guard < 2000) begin
      bus.s_valid = bursty ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.s_data  = in_word(k, seed);
      @(negedge clk);
      acc = bus.s_valid && bus.s_ready;
      @(posedge clk); #1;
      if (acc) k++;
      guard++;
    end
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    chk("feed_words", 32'(k), 32'(n));
  endtask

  task automatic wait_seq_done(input int limit);
    int i;
    i = 0;
    while (done_cnt == 0 && i < limit) begin
      @(posedge clk); #1;
      i++;
    end
    chk("seq_done_seen", 32'(done_cnt), 32'd1);
  endtask

  task automatic finish_checks(input string tag, input int nwr);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_wr_cnt"}, 32'(wr_cnt), 32'(nwr));
    chk({tag, "_go_cnt"}, 32'(go_cnt), 32'd1);
    chk({tag, "_rd_cnt"}, 32'(rd_exp), 32'(HT_LEN));
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, "_wq_left"}, 32'(wq.size()), 32'd0);
    chk({tag, "_mq_left"}, 32'(mq.size()), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  // Sampled at negedge: every output at its idle/reset value.
  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_mem_sel"}, 32'(bus.acc_mem_sel), 32'd1);
    chk({tag, "_s_ready"}, 32'(bus.s_ready), 32'd0);
    chk({tag, "_m_valid"}, 32'(bus.m_valid), 32'd0);
    chk({tag, "_m_data"}, 32'(bus.m_data), 32'd0);
    chk({tag, "_go"}, 32'(bus.acc_go), 32'd0);
    chk({tag, "_mem_wr"}, 32'(bus.acc_mem_wr), 32'd0);
    chk({tag, "_mem_rd"}, 32'(bus.acc_mem_rd), 32'd0);
    chk({tag, "_addr"}, 32'(bus.acc_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(bus.acc_wdata), 32'd0);
    chk({tag, "_seq_done"}, 32'(seq_done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk_idle(tag);
    @(posedge clk); #1;
    wq.delete();
    mq.delete();
  endtask

  initial begin : watchdog
    #400000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int i;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle("rst");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Full sequence with coefficient load; a start pulse while busy is ignored
    seed = 16'h0000;
    start_seq(1'b1, 1'b1);
    feed(int'(CW_LEN + FM_LEN + COEF_LEN), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; load_coef = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_seq_done(1000);
    finish_checks("full", int'(CW_LEN + FM_LEN + COEF_LEN));

    // No coefficient phase: go on the cycle after the last feature-map write
    seed = 16'h0055;
    start_seq(1'b0, 1'b1);
    feed(int'(CW_LEN + FM_LEN), 1'b0);
    wait_seq_done(1000);
    finish_checks("nocoef", int'(CW_LEN + FM_LEN));
    chk("nocoef_go_timing", 32'(go_cyc), 32'(last_wr_cyc + 1));

    // Bursty input and stalled consumer
    seed = 16'h0A0A;
    mr_mode = 1;
    start_seq(1'b1, 1'b1);
    feed(int'(CW_LEN + FM_LEN + COEF_LEN), 1'b1);
    wait_seq_done(3000);
    finish_checks("burst", int'(CW_LEN + FM_LEN + COEF_LEN));
    mr_mode = 0;

    // Timeout: done never arrives
    seed = 16'h0123;
    done_en = 1'b0;
    start_seq(1'b0, 1'b0);
    feed(int'(CW_LEN + FM_LEN), 1'b0);
    i = 0;
    while (!err && i < 400) begin
      @(negedge clk);
      i++;
    end
    chk("to_err", 32'(err), 32'd1);
    chk("to_latency", 32'(cyc - go_cyc), 32'(TIMEOUT + 2));
    chk("to_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    chk("to_no_seq_done", 32'(done_cnt), 32'd0);
    chk("to_no_reads", 32'(rd_exp), 32'd0);
    chk("to_err_sticky", 32'(err), 32'd1);

    // Next start clears err and runs normally
    done_en = 1'b1;
    seed = 16'h0777;
    start_seq(1'b1, 1'b1);
    @(negedge clk);
    chk("err_cleared", 32'(err), 32'd0);
    @(posedge clk); #1;
    feed(int'(CW_LEN + FM_LEN + COEF_LEN), 1'b0);
    wait_seq_done(1000);
    finish_checks("rerun", int'(CW_LEN + FM_LEN + COEF_LEN));

    // Reset during LD_FM
    seed = 16'h0300;
    start_seq(1'b1, 1'b1);
    feed(int'(CW_LEN) + 2, 1'b0);
    pulse_reset("rst_ldfm");
    repeat (30) @(posedge clk);
    #1;
    chk("rst_ldfm_wr_cnt", 32'(wr_cnt), 32'(CW_LEN + 2));
    chk("rst_ldfm_go_cnt", 32'(go_cnt), 32'd0);

    // Reset during RD_OUT
    seed = 16'h0440;
    mr_mode = 2;
    start_seq(1'b1, 1'b1);
    feed(int'(CW_LEN + FM_LEN + COEF_LEN), 1'b0);
    i = 0;
    while (!bus.m_valid && i < 200) begin
      @(negedge clk);
      i++;
    end
    chk("rdout_reached", 32'(bus.m_valid), 32'd1);
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;
    pulse_reset("rst_rdout");
    mr_mode = 0;
    repeat (30) @(posedge clk);
    #1;
    chk("rst_rdout_go_cnt", 32'(go_cnt), 32'd1);
    chk("rst_rdout_rd_cnt", 32'(rd_exp), 32'd1);
    chk("rst_rdout_done_cnt", 32'(done_cnt), 32'd0);
    chk("rst_rdout_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/accel_host_sequencer.md
Name: accel_host_sequencer

Overview:
- Host-side control stage directly upstream of the CNN-LSTM accelerator top level; it drives that top level's mem_sel/data/address/mem_wr/mem_rd/go inputs and consumes its data_out/done outputs.
- Accepts one valid/ready input stream and loads, in order, conv weights, the conv feature map and (optionally) the LSTM coefficient memory.
- Pulses go, waits for done with a timeout, then reads back the h_t memory as a valid/ready output stream.

Parameters:
DATA_W, 16, word width; matches accelerator data width
ADDR_W, 10, accelerator address width
CW_LEN, 72, conv weight words to load (mem_sel=2'b11)
FM_LEN, 784, feature-map words to load (mem_sel=2'b00)
COEF_LEN, 512, LSTM coefficient words to load (mem_sel=2'b10)
HT_LEN, 32, h_t words to read back (mem_sel=2'b01)
RD_LAT, 1, cycles from mem_rd issue to valid acc_rdata (1..3)
TIMEOUT, 1048575, max cycles waiting for acc_done

Ports:
clk  in  1  clock
reset  in  1  sync active-high reset
start  in  1  begin sequence; sampled only in IDLE
load_coef  in  1  sampled with start; 1 = perform coefficient load phase
s_valid  in  1  input word valid
s_ready  out  1  sequencer accepts word
s_data  in  DATA_W  input word
m_valid  out  1  h_t result word valid
m_ready  in  1  consumer accepts result
m_data  out  DATA_W  h_t result word
acc_mem_sel  out  2  to accelerator mem_sel
acc_wdata  out  DATA_W  to accelerator data_in
acc_addr  out  ADDR_W  to accelerator addrs_in
acc_mem_wr  out  1  to accelerator mem_wr
acc_mem_rd  out  1  to accelerator mem_rd
acc_go  out  1  to accelerator go; one-cycle pulse
acc_rdata  in  DATA_W  from accelerator data_out
acc_done  in  1  from accelerator done (pulse or level)
busy  out  1  high in every state except IDLE
seq_done  out  1  one-cycle pulse after last h_t word accepted
err  out  1  sticky timeout flag; cleared by next accepted start

Behaviour:
- Reset: state IDLE; all outputs 0 (acc_mem_sel=2'b01); idx=0; err=0. Reset mid-sequence aborts immediately; no further acc_mem_wr/acc_go.
- States: IDLE, LD_CW, LD_FM, LD_COEF, GO, WAIT, RD_ISSUE, RD_WAIT, RD_OUT, FIN.
- IDLE: acc_mem_sel=2'b01, wr/rd=0. start=1 latches load_coef, clears err, idx=0 -> LD_CW.
- LD_x phases: acc_mem_sel = phase code; s_ready=1. On s_valid&&s_ready, same cycle: acc_mem_wr=1, acc_wdata=s_data, acc_addr=idx (combinational pass-through), idx++. Otherwise acc_mem_wr=0. The write on idx==LEN-1 moves to the next phase with idx=0. Order: LD_CW -> LD_FM -> LD_COEF (skipped if latched load_coef=0) -> GO.
- GO: acc_mem_sel=2'b01, acc_go=1 for exactly one cycle; s_ready=0 -> WAIT.
- WAIT: acc_mem_sel=2'b01, timer counts from 0. acc_done is only observed from the cycle after the go pulse. When acc_done=1, timer reset and idx=0 -> RD_ISSUE. If timer reaches TIMEOUT first, err=1 -> IDLE; no seq_done.
- RD_ISSUE: acc_mem_sel=2'b01, acc_addr=idx, acc_mem_rd=1 for one cycle -> RD_WAIT.
- RD_WAIT: acc_mem_rd=0, acc_addr held. After RD_LAT cycles counted from the issue cycle, capture acc_rdata into m_data -> RD_OUT.
- RD_OUT: m_valid=1; m_data stable while m_ready=0. On m_ready, m_valid drops next cycle and idx++. At idx==HT_LEN-1 -> FIN; otherwise -> RD_ISSUE.
- Per-word read cost: 1 + RD_LAT + handshake cycles.
- FIN: seq_done=1 for one cycle -> IDLE.
- s_ready=0 outside LD_ states. start while busy is ignored. s_valid with s_ready=0 is not consumed.
- Counters idx and timer are wide enough for max(LEN) and TIMEOUT; no wrap within a phase.
- All outputs are registered, except s_ready, acc_mem_wr, acc_wdata and acc_addr in LD_ states, which are combinational from state/s_valid/s_data/idx.

Test Plan:
- Full sequence, CW_LEN=4, FM_LEN=6, COEF_LEN=3, load_coef=1, s_valid always 1 -> exactly 13 writes with mem_sel 11,11,11,11,00x6,10x3; one acc_go; model done after 20 cycles; 32 reads addr 0..31; m_data matches model; one seq_done.
- load_coef=0 -> no acc_mem_sel=2'b10 writes; acc_go on the cycle after the 10th write.
- Bursty s_valid (50% random) plus m_ready stalls of 5 cycles -> no dropped or duplicated words; m_data constant during stall.
- acc_done never asserts, TIMEOUT=100 -> err=1 about 101 cycles after go; state IDLE; no seq_done. Next start clears err.
- RD_LAT=3 -> m_data equals the model word at the issued address, not its neighbour.
- reset asserted during LD_FM and again during RD_OUT -> next cycle: all outputs 0, acc_mem_sel=01, busy=0. start while busy is ignored.
